// File: rtl/gray_to_rgb565_expander_if.sv
// Custom-instruction bus between the CPU and the gray-to-RGB565 expander.
// master drives the instruction operands; slave returns the completion pulse and result.
interface gray_to_rgb565_expander_if;
    logic        start;
    logic [31:0] valueA;
    logic [31:0] valueB;
    logic [7:0]  iseId;
    logic        done;
    logic [31:0] result;

    modport master (
        output start,
        output valueA,
        output valueB,
        output iseId,
        input  done,
        input  result
    );

    modport slave (
        input  start,
        input  valueA,
        input  valueB,
        input  iseId,
        output done,
        output result
    );
endinterface

// File: rtl/gray_to_rgb565_expander.sv
// Expands four packed gray bytes to byte-swapped RGB565, with an optional saturating brightness
// offset. Pixels 0/1 are returned directly; pixels 2/3 wait in a one-entry buffer for FETCH.
module gray_to_rgb565_expander #(
    parameter logic [7:0] customInstructionId = 8'd0
) (
    input logic                       clock,
    input logic                       reset,
    gray_to_rgb565_expander_if.slave  ci
);

    typedef enum logic [1:0] {StIdle, StCalc, StResp} state_e;

    state_e      state_q, state_d;
    logic [31:0] gray_q, gray_d;
    logic [7:0]  offset_q, offset_d;
    logic [31:0] buf_q, buf_d;
    logic        buf_valid_q, buf_valid_d;
    logic [15:0] conv_count_q, conv_count_d;
    logic        done_q, done_d;
    logic [31:0] result_q, result_d;
    logic [15:0] pix [4];
    logic        is_my_ci;
    logic        unused_valueb;

    // Saturating brightness adjust, then packing into camera byte order {G[2:0],B,R,G[5:3]}.
    function automatic logic [15:0] expand_pixel(input logic [7:0] gray, input logic [7:0] offset);
        logic signed [9:0] sum;
        logic [7:0]        sat;
        logic [5:0]        g6;
        logic [4:0]        rb5;
        sum = $signed({2'b00, gray}) + $signed({{2{offset[7]}}, offset});
        if (sum < 0) begin
            sat = 8'd0;
        end else if (sum > 10'sd255) begin
            sat = 8'hFF;
        end else begin
            sat = sum[7:0];
        end
        g6  = sat[7:2];
        rb5 = sat[7:3];
        return {g6[2:0], rb5, rb5, g6[5:3]};
    endfunction

    assign is_my_ci      = ci.start & (ci.iseId == customInstructionId);
    assign unused_valueb = ^{ci.valueB[31:16], ci.valueB[7:2]};

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            pix[k] = expand_pixel(gray_q[8*k +: 8], offset_q);
        end
    end

    always_comb begin
        state_d      = state_q;
        gray_d       = gray_q;
        offset_d     = offset_q;
        buf_d        = buf_q;
        buf_valid_d  = buf_valid_q;
        conv_count_d = conv_count_q;
        done_d       = 1'b0;
        result_d     = 32'd0;

        unique case (state_q)
            StIdle: begin
                if (is_my_ci) begin
                    unique case (ci.valueB[1:0])
                        2'd0: begin
                            gray_d   = ci.valueA;
                            offset_d = ci.valueB[15:8];
                            state_d  = StCalc;
                        end
                        2'd1: begin
                            done_d      = 1'b1;
                            result_d    = buf_valid_q ? buf_q : 32'd0;
                            buf_valid_d = 1'b0;
                            state_d     = StResp;
                        end
                        2'd2: begin
                            done_d   = 1'b1;
                            result_d = {conv_count_q, 15'd0, buf_valid_q};
                            state_d  = StResp;
                        end
                        default: begin
                            done_d       = 1'b1;
                            buf_valid_d  = 1'b0;
                            conv_count_d = 16'd0;
                            state_d      = StResp;
                        end
                    endcase
                end
            end
            StCalc: begin
                done_d       = 1'b1;
                result_d     = {pix[1], pix[0]};
                buf_d        = {pix[3], pix[2]};
                buf_valid_d  = 1'b1;
                conv_count_d = conv_count_q + 16'd1;
                state_d      = StResp;
            end
            StResp: begin
                // done_q/result_q are live this cycle; registers above already default to zero.
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            gray_q       <= 32'd0;
            offset_q     <= 8'd0;
            buf_q        <= 32'd0;
            buf_valid_q  <= 1'b0;
            conv_count_q <= 16'd0;
            done_q       <= 1'b0;
            result_q     <= 32'd0;
        end else begin
            state_q      <= state_d;
            gray_q       <= gray_d;
            offset_q     <= offset_d;
            buf_q        <= buf_d;
            buf_valid_q  <= buf_valid_d;
            conv_count_q <= conv_count_d;
            done_q       <= done_d;
            result_q     <= result_d;
        end
    end

    assign ci.done   = done_q;
    assign ci.result = result_q;

endmodule

// File: tb/tb_gray_to_rgb565_expander.sv
// Bench for gray_to_rgb565_expander: directed vectors plus random instruction streams
// compared against an arithmetic reference model of the instruction set.
module tb_gray_to_rgb565_expander;

    localparam logic [7:0] MyId = 8'h2A;

    logic clock = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    // Reference model state
    bit          m_valid;
    logic [31:0] m_buf;
    logic [15:0] m_count;

    always #5 clock = ~clock;

    gray_to_rgb565_expander_if ci_bus ();

    gray_to_rgb565_expander #(
        .customInstructionId (MyId)
    ) dut (
        .clock (clock),
        .reset (reset),
        .ci    (ci_bus.slave)
    );

    function automatic logic [15:0] ref_pixel(input int g, input int off);
        int s;
        s = g + off;
        if (s < 0) s = 0;
        if (s > 255) s = 255;
        return 16'((((s >> 2) & 7) << 13) | ((s >> 3) << 8) | ((s >> 3) << 3) | (s >> 5));
    endfunction

    task automatic model_reset();
        m_valid = 1'b0;
        m_buf   = 32'd0;
        m_count = 16'd0;
    endtask

    task automatic model_exec(input logic [31:0] a, input logic [31:0] b,
                              output logic [31:0] exp_res, output int exp_lat);
        logic signed [7:0] o;
        logic [15:0]       p [4];
        o = b[15:8];
        case (b[1:0])
            2'd0: begin
                for (int k = 0; k < 4; k++) p[k] = ref_pixel(int'(a[8*k +: 8]), int'(o));
                exp_res = {p[1], p[0]};
                m_buf   = {p[3], p[2]};
                m_valid = 1'b1;
                m_count = m_count + 16'd1;
                exp_lat = 1;
            end
            2'd1: begin
                exp_res = m_valid ? m_buf : 32'd0;
                m_valid = 1'b0;
                exp_lat = 0;
            end
            2'd2: begin
                exp_res = {m_count, 15'd0, m_valid};
                exp_lat = 0;
            end
            default: begin
                exp_res = 32'd0;
                m_valid = 1'b0;
                m_count = 16'd0;
                exp_lat = 0;
            end
        endcase
    endtask

    // Issues one instruction; lat counts clock edges after the sampling edge before done (-1: none).
    task automatic issue(input logic [7:0] id, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output logic [31:0] res, output int width,
                         output int dirty);
        ci_bus.start  = 1'b1;
        ci_bus.valueA = a;
        ci_bus.valueB = b;
        ci_bus.iseId  = id;
        @(posedge clock); #1;
        ci_bus.start = 1'b0;
        lat   = -1;
        res   = 32'd0;
        width = 0;
        dirty = 0;
        for (int c = 0; c < 8; c++) begin
            if (ci_bus.done === 1'b1) begin
                lat = c;
                res = ci_bus.result;
                break;
            end
            if (ci_bus.result !== 32'd0) dirty++;
            @(posedge clock); #1;
        end
        if (lat >= 0) begin
            width = 1;
            @(posedge clock); #1;
            if (ci_bus.done !== 1'b0) width++;
            else if (ci_bus.result !== 32'd0) dirty++;
        end
    endtask

    task automatic test_reset();
        int lat, width, dirty;
        logic [31:0] res;
        ci_bus.start  = 1'b0;
        ci_bus.valueA = 32'd0;
        ci_bus.valueB = 32'd0;
        ci_bus.iseId  = 8'd0;
        reset = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clock); #1;
            checks++;
            if (ci_bus.done !== 1'b0 || ci_bus.result !== 32'd0) begin
                errors++;
                $display("FAIL reset_outputs: done=%b result=%h, required done=0 result=0",
                         ci_bus.done, ci_bus.result);
            end
        end
        reset = 1'b0;
        model_reset();
        issue(MyId, 32'd0, 32'd2, lat, res, width, dirty);
        checks++;
        if (lat !== 0 || res !== 32'h0) begin
            errors++;
            $display("FAIL reset_status: lat=%0d result=%h, required lat=0 result=00000000",
                     lat, res);
        end
    endtask

    task automatic test_convert_fetch();
        int lat, width, dirty, elat;
        logic [31:0] res, eres;
        model_exec(32'h0080FF00, 32'd0, eres, elat);
        issue(MyId, 32'h0080FF00, 32'd0, lat, res, width, dirty);
        checks++;
        if (lat !== 1 || res !== 32'hFFFF0000 || width !== 1) begin
            errors++;
            $display("FAIL convert: lat=%0d result=%h width=%0d, required lat=1 result=ffff0000 width=1",
                     lat, res, width);
        end
        model_exec(32'd0, 32'd1, eres, elat);
        issue(MyId, 32'd0, 32'd1, lat, res, width, dirty);
        checks++;
        if (lat !== 0 || res !== 32'h00001084) begin
            errors++;
            $display("FAIL fetch1: lat=%0d result=%h, required lat=0 result=00001084", lat, res);
        end
        model_exec(32'd0, 32'd1, eres, elat);
        issue(MyId, 32'd0, 32'd1, lat, res, width, dirty);
        checks++;
        if (lat !== 0 || res !== 32'h0) begin
            errors++;
            $display("FAIL fetch2_empty: lat=%0d result=%h, required lat=0 result=00000000",
                     lat, res);
        end
    endtask

    task automatic test_saturation();
        int lat, width, dirty, elat;
        logic [31:0] res, eres;
        model_exec(32'hF0F0F0F0, 32'h00002000, eres, elat);
        issue(MyId, 32'hF0F0F0F0, 32'h00002000, lat, res, width, dirty);
        checks++;
        if (lat !== 1 || res !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL sat_high: lat=%0d result=%h, required lat=1 result=ffffffff", lat, res);
        end
        model_exec(32'd0, 32'd1, eres, elat);
        issue(MyId, 32'd0, 32'd1, lat, res, width, dirty);
        checks++;
        if (res !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL sat_high_fetch: result=%h, required ffffffff", res);
        end
        model_exec(32'h10101010, 32'h0000E000, eres, elat);
        issue(MyId, 32'h10101010, 32'h0000E000, lat, res, width, dirty);
        checks++;
        if (lat !== 1 || res !== 32'h0) begin
            errors++;
            $display("FAIL sat_low: lat=%0d result=%h, required lat=1 result=00000000", lat, res);
        end
    endtask

    task automatic test_id_status();
        int lat, width, dirty, elat;
        logic [31:0] res, eres;
        issue(MyId ^ 8'h01, 32'h12345678, 32'd0, lat, res, width, dirty);
        checks++;
        if (lat !== -1) begin
            errors++;
            $display("FAIL id_filter: done seen after %0d edges, required no done", lat);
        end
        model_exec(32'd0, 32'd3, eres, elat);
        issue(MyId, 32'd0, 32'd3, lat, res, width, dirty);
        checks++;
        if (lat !== 0 || res !== 32'h0) begin
            errors++;
            $display("FAIL clear1: lat=%0d result=%h, required lat=0 result=00000000", lat, res);
        end
        for (int i = 0; i < 2; i++) begin
            model_exec(32'h55AA33CC, 32'd0, eres, elat);
            issue(MyId, 32'h55AA33CC, 32'd0, lat, res, width, dirty);
        end
        issue(MyId, 32'd0, 32'd2, lat, res, width, dirty);
        checks++;
        if (res !== 32'h00020001) begin
            errors++;
            $display("FAIL status_two_conv: result=%h, required 00020001", res);
        end
        model_exec(32'd0, 32'd3, eres, elat);
        issue(MyId, 32'd0, 32'd3, lat, res, width, dirty);
        issue(MyId, 32'd0, 32'd2, lat, res, width, dirty);
        checks++;
        if (res !== 32'h0) begin
            errors++;
            $display("FAIL status_after_clear: result=%h, required 00000000", res);
        end
    endtask

    task automatic test_reset_mid_op();
        int lat, width, dirty, elat, seen;
        logic [31:0] res, eres;
        // Leave valid data in the buffer so the following FETCH shows the reset cleared it.
        model_exec(32'hA0B0C0D0, 32'd0, eres, elat);
        issue(MyId, 32'hA0B0C0D0, 32'd0, lat, res, width, dirty);
        ci_bus.start  = 1'b1;
        ci_bus.valueA = 32'h11223344;
        ci_bus.valueB = 32'd0;
        ci_bus.iseId  = MyId;
        @(posedge clock); #1;
        ci_bus.start = 1'b0;
        reset        = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        model_reset();
        seen = 0;
        for (int c = 0; c < 4; c++) begin
            if (ci_bus.done !== 1'b0) seen++;
            @(posedge clock); #1;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL reset_abort: done high in %0d cycles, required 0", seen);
        end
        issue(MyId, 32'd0, 32'd1, lat, res, width, dirty);
        checks++;
        if (lat !== 0 || res !== 32'h0) begin
            errors++;
            $display("FAIL reset_fetch: lat=%0d result=%h, required lat=0 result=00000000",
                     lat, res);
        end
        issue(MyId, 32'd0, 32'd2, lat, res, width, dirty);
        checks++;
        if (res !== 32'h0) begin
            errors++;
            $display("FAIL reset_status: result=%h, required 00000000", res);
        end
    endtask

    task automatic test_back_to_back();
        int lat, width, dirty, elat;
        logic [31:0] res, eres, a, b;
        for (int i = 0; i < 60; i++) begin
            a = $urandom;
            b = $urandom;
            // Bias toward convert so FETCH frequently finds a valid buffer.
            if ($urandom_range(0, 2) == 0) b[1:0] = 2'd0;
            model_exec(a, b, eres, elat);
            issue(MyId, a, b, lat, res, width, dirty);
            checks++;
            if (lat !== elat || res !== eres) begin
                errors++;
                $display("FAIL random_op%0d: op=%0d lat=%0d result=%h, required lat=%0d result=%h",
                         i, b[1:0], lat, res, elat, eres);
            end
            checks++;
            if (width !== 1 || dirty !== 0) begin
                errors++;
                $display("FAIL hygiene%0d: done_width=%0d nonzero_idle_results=%0d, required 1 and 0",
                         i, width, dirty);
            end
        end
    endtask

    initial begin
        test_reset();
        test_convert_fetch();
        test_saturation();
        test_id_status();
        test_reset_mid_op();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
